pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the fetch/decode/execute core. It sits beside the IF_ID and ID_EX pipeline registers and drives their enables, flushes and bubble injection. It resolves read-after-write hazards (the core has no forwarding), multi-cycle MUL occupancy of EX, taken-branch flushes, and HLT/resume.

---
 rtl/pipe_ctrl_pkg.sv | 52 +++++
 rtl/pipe_ctrl_hazard_detect.sv | 54 +++++
 rtl/pipe_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
// Opcodes, one-hot EX control bit positions, masks and FSM state encoding.
// Imported by pipe_ctrl and hazard_detect.
package pipe_ctrl_pkg;

  // 6-bit opcodes in instr[31:26]
  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_LI  = 6'h02;
  localparam logic [5:0] OP_SHL = 6'h03;
  localparam logic [5:0] OP_SHR = 6'h04;
  localparam logic [5:0] OP_AND = 6'h05;
  localparam logic [5:0] OP_OR  = 6'h06;
  localparam logic [5:0] OP_XOR = 6'h07;
  localparam logic [5:0] OP_BR  = 6'h08;
  localparam logic [5:0] OP_BNE = 6'h09;
  localparam logic [5:0] OP_MOV = 6'h0A;
  localparam logic [5:0] OP_ADI = 6'h0B;
  localparam logic [5:0] OP_MUL = 6'h0C;
  localparam logic [5:0] OP_HLT = 6'h0D;
  localparam logic [5:0] OP_NOP = 6'h0E;

  // Bit positions inside the one-hot EX control word
  localparam int unsigned B_ADD = 0;
  localparam int unsigned B_SUB = 1;
  localparam int unsigned B_LI  = 2;
  localparam int unsigned B_SHL = 3;
  localparam int unsigned B_SHR = 4;
  localparam int unsigned B_AND = 5;
  localparam int unsigned B_OR  = 6;
  localparam int unsigned B_XOR = 7;
  localparam int unsigned B_BR  = 8;
  localparam int unsigned B_BNE = 9;
  localparam int unsigned B_MOV = 10;
  localparam int unsigned B_ADI = 11;
  localparam int unsigned B_MUL = 12;
  localparam int unsigned B_HLT = 13;
  localparam int unsigned B_NOP = 14;

  // EX instructions that write a destination register
  localparam logic [15:0] WRITER_MASK = 16'h1CFF;
  // Control word loaded into ID_EX when a bubble is injected
  localparam logic [15:0] NOP_CTRL    = 16'h4000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULW  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// RAW hazard detector: decodes which source fields the ID instruction reads
// and compares them against the EX and MEM/WB destinations.
// Purely combinational; no state, no backpressure of its own.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] id_instr_i,
  input  logic        id_valid_i,
  input  logic [15:0] ex_op_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_wr_i,
  output logic        raw_hit_o
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       use_rs;
  logic       use_rt;
  logic       ex_writes;
  logic       rs_hit;
  logic       rt_hit;
  logic       unused_imm;

  assign opcode     = id_instr_i[31:26];
  assign rs         = id_instr_i[25:21];
  assign rt         = id_instr_i[20:16];
  assign unused_imm = ^id_instr_i[15:0];

  // Source-field usage per opcode; unknown opcodes conservatively read both
  always_comb begin
    use_rs = 1'b1;
    use_rt = 1'b1;
    case (opcode)
      OP_LI, OP_BR, OP_HLT, OP_NOP: begin
        use_rs = 1'b0;
        use_rt = 1'b0;
      end
      OP_SHL, OP_SHR, OP_MOV, OP_ADI: begin
        use_rt = 1'b0;
      end
      default: ;
    endcase
  end

  // Register 0 is an ordinary register here, so no zero-register exemption
  assign ex_writes = ex_valid_i & (|(ex_op_i & WRITER_MASK));
  assign rs_hit    = use_rs & ((ex_writes & (rs == ex_rd_i)) | (mem_wr_i & (rs == mem_rd_i)));
  assign rt_hit    = use_rt & ((ex_writes & (rt == ex_rd_i)) | (mem_wr_i & (rt == mem_rd_i)));
  assign raw_hit_o = id_valid_i & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: IF_ID/ID_EX enables, flushes, bubbles for RAW, MUL, branch, HLT.
// Outputs are combinational from registered state/counters and current inputs.
// Optional stall counter enabled by macro PIPE_CTRL_PERF_EN (tied to zero otherwise).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic [15:0] ex_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_valid,
  input  logic [4:0]  mem_rd,
  input  logic        mem_wr,
  input  logic        branch_taken,
  input  logic        resume,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_hold,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  localparam logic [3:0] MCNT_INIT = 4'(MUL_CYCLES - 2);
  localparam logic [2:0] FCNT_INIT = (FLUSH_DEPTH > 1) ? 3'(FLUSH_DEPTH - 2) : 3'd0;

  state_e     state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       raw_hit;
  logic       run_eval;
  logic       mul_ok;
  logic       br_hit;
  logic       hlt_hit;

  hazard_detect u_hazard (
    .id_instr_i (id_instr),
    .id_valid_i (id_valid),
    .ex_op_i    (ex_op),
    .ex_rd_i    (ex_rd),
    .ex_valid_i (ex_valid),
    .mem_rd_i   (mem_rd),
    .mem_wr_i   (mem_wr),
    .raw_hit_o  (raw_hit)
  );

  assign br_hit  = ex_valid & branch_taken;
  assign hlt_hit = id_valid & (id_instr[31:26] == OP_HLT);
  assign state   = state_q;

  // Next-state and control decode; RUN rules are shared with the MUL release cycle
  always_comb begin
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    fcnt_d       = fcnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    halted       = 1'b0;
    run_eval     = 1'b0;
    mul_ok       = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_eval = 1'b1;
        mul_ok   = 1'b1;
      end
      ST_MULW: begin
        if (mcnt_q != 4'd0) begin
          ex_hold  = 1'b1;
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          mcnt_d   = mcnt_q - 4'd1;
        end else begin
          // The MUL is still in EX this cycle; do not start another wait on it
          run_eval = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if_id_en     = 1'b0;
        if (fcnt_q == 3'd0) state_d = ST_RUN;
        else                fcnt_d  = fcnt_q - 3'd1;
      end
      ST_HALT: begin
        halted       = 1'b1;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        if (resume) begin
          if_id_flush = 1'b1;
          pc_en       = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Taken branch wins so a HLT or RAW in decode is flushed rather than acted on
    if (run_eval) begin
      if (br_hit) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if_id_en     = 1'b0;
        if (FLUSH_DEPTH > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_INIT;
        end
      end else if (mul_ok && ex_valid && ex_op[B_MUL]) begin
        ex_hold  = 1'b1;
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        mcnt_d   = MCNT_INIT;
        state_d  = ST_MULW;
      end else if (hlt_hit) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        state_d      = ST_HALT;
      end else if (raw_hit) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    // Reset forces a flushed, frozen pipeline without waiting for a clock
    if (!reset_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_hold      = 1'b0;
      halted       = 1'b0;
    end
  end

  // FSM state and occupancy/flush counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      mcnt_q  <= 4'd0;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q;

  // Count frozen-PC cycles outside HALT, saturating at all-ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 16'h0000;
    end else if (!pc_en && !halted && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MUL_CYCLES=4, FLUSH_DEPTH=2).
// Inputs driven 1 time unit after the rising edge, outputs checked on the falling edge.
// Works with and without PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [15:0] ex_op;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic [4:0]  mem_rd;
  logic        mem_wr;
  logic        branch_taken;
  logic        resume;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_hold;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int compared   = 0;
  int mismatched = 0;
  int stalls     = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, halted}
  localparam logic [15:0] C_RUN    = 16'h0030;
  localparam logic [15:0] C_STALL  = 16'h0004;
  localparam logic [15:0] C_MUL    = 16'h0002;
  localparam logic [15:0] C_RST    = 16'h000C;
  localparam logic [15:0] C_HALT   = 16'h0005;
  localparam logic [15:0] C_RESUME = 16'h002D;
  localparam logic [15:0] C_FLUSH  = 16'h002C; // compared with if_id_en masked off

  localparam logic [31:0] I_NOP     = 32'h38000000;
  localparam logic [31:0] I_HLT     = 32'h34000000;
  localparam logic [31:0] I_ADD57   = 32'h00A70000; // ADD rs=5 rt=7
  localparam logic [31:0] I_ADD00   = 32'h00000000; // ADD rs=0 rt=0
  localparam logic [31:0] I_SHL17   = 32'h0C270000; // SHL rs=1 (rt field 7 ignored)
  localparam logic [31:0] I_LI5     = 32'h08A00000; // LI with rs field 5 (ignored)

  pipe_ctrl #(.MUL_CYCLES(4), .FLUSH_DEPTH(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .ex_op        (ex_op),
    .ex_rd        (ex_rd),
    .ex_valid     (ex_valid),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .branch_taken (branch_taken),
    .resume       (resume),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_hold      (ex_hold),
    .halted       (halted),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ctl();
    return {10'd0, pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, halted};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp);
    chk(tag, {14'd0, state}, {14'd0, exp});
  endtask

  task automatic chk_stall(input string tag);
    chk(tag, stall_cycles, PERF ? 16'(stalls) : 16'h0000);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; id_instr = I_NOP; id_valid = 1'b0; ex_op = 16'h4000; ex_rd = 5'd0;
    ex_valid = 1'b0; mem_rd = 5'd0; mem_wr = 1'b0; branch_taken = 1'b0; resume = 1'b0;
    #2;
    chk("reset_ctl", ctl(), C_RST);
    chk_st("reset_state", 2'd0);
    chk_stall("reset_stall");
    next_cycle();
    reset_n = 1'b1;

    // Normal advance
    id_valid = 1'b1; id_instr = I_NOP; ex_valid = 1'b1; ex_op = 16'h4000;
    settle(); chk("normal_ctl", ctl(), C_RUN); chk_st("normal_state", 2'd0);
    next_cycle();

    // RAW on rs against EX ADD writing r5, then EX turns to NOP
    ex_op = 16'h0001; ex_rd = 5'd5; id_instr = I_ADD57;
    settle(); chk("raw_ex_rs", ctl(), C_STALL); stalls++;
    next_cycle();
    ex_op = 16'h4000;
    settle(); chk("raw_clear", ctl(), C_RUN);
    next_cycle();
    // RAW on rt against MEM/WB writer
    mem_rd = 5'd7; mem_wr = 1'b1;
    settle(); chk("raw_mem_rt", ctl(), C_STALL); stalls++;
    next_cycle();
    mem_wr = 1'b0;
    settle(); chk("raw_mem_nowr", ctl(), C_RUN);
    next_cycle();
    // SHL does not read rt
    id_instr = I_SHL17; mem_wr = 1'b1;
    settle(); chk("shl_no_rt", ctl(), C_RUN);
    next_cycle();
    // LI reads no sources
    mem_wr = 1'b0; id_instr = I_LI5; ex_op = 16'h0001; ex_rd = 5'd5;
    settle(); chk("li_no_src", ctl(), C_RUN);
    next_cycle();
    // EX instruction not live means no hazard
    id_instr = I_ADD57; ex_valid = 1'b0;
    settle(); chk("ex_invalid", ctl(), C_RUN);
    next_cycle();
    // BR is not a writer
    ex_valid = 1'b1; ex_op = 16'h0100;
    settle(); chk("br_not_writer", ctl(), C_RUN);
    next_cycle();
    // r0 hazards are real
    id_instr = I_ADD00; ex_op = 16'h0001; ex_rd = 5'd0;
    settle(); chk("raw_r0", ctl(), C_STALL); stalls++;
    next_cycle();
    id_instr = I_NOP; ex_op = 16'h4000; ex_rd = 5'd9;
    settle(); chk("after_raw", ctl(), C_RUN); chk_stall("stall_after_raw");
    next_cycle();

    // MUL occupancy: 3 hold cycles then release with the MUL still in EX
    ex_op = 16'h1000;
    settle(); chk("mul_a", ctl(), C_MUL); chk_st("mul_a_st", 2'd0); stalls++;
    next_cycle();
    settle(); chk("mul_b", ctl(), C_MUL); chk_st("mul_b_st", 2'd1); stalls++;
    next_cycle();
    settle(); chk("mul_c", ctl(), C_MUL); chk_st("mul_c_st", 2'd1); stalls++;
    next_cycle();
    settle(); chk("mul_rel", ctl(), C_RUN); chk_st("mul_rel_st", 2'd1);
    next_cycle();
    ex_op = 16'h4000;
    settle(); chk("mul_done", ctl(), C_RUN); chk_st("mul_done_st", 2'd0);
    chk_stall("stall_after_mul");
    next_cycle();

    // Taken branch with HLT in decode: two flush cycles, no halt
    ex_op = 16'h0100; branch_taken = 1'b1; id_instr = I_HLT;
    settle(); chk("br1", ctl() & ~16'h0010, C_FLUSH); chk_st("br1_st", 2'd0);
    next_cycle();
    branch_taken = 1'b0; ex_valid = 1'b0;
    settle(); chk("br2", ctl() & ~16'h0010, C_FLUSH); chk_st("br2_st", 2'd2);
    next_cycle();
    id_valid = 1'b0; ex_valid = 1'b1; ex_op = 16'h4000;
    settle(); chk("br_done", ctl(), C_RUN); chk_st("br_done_st", 2'd0);
    next_cycle();
    // branch_taken without ex_valid is ignored
    id_valid = 1'b1; id_instr = I_NOP; ex_valid = 1'b0; branch_taken = 1'b1;
    settle(); chk("br_unqual", ctl(), C_RUN);
    next_cycle();
    branch_taken = 1'b0; ex_valid = 1'b1;

    // HLT: resume in the detection cycle is ignored
    id_instr = I_HLT; resume = 1'b1;
    settle(); chk("hlt_det", ctl(), C_STALL); chk_st("hlt_det_st", 2'd0); stalls++;
    next_cycle();
    resume = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle(); chk("halt_hold", ctl(), C_HALT); chk_st("halt_st", 2'd3);
      next_cycle();
    end
    resume = 1'b1;
    settle(); chk("resume", ctl(), C_RESUME);
    next_cycle();
    resume = 1'b0; id_valid = 1'b0;
    settle(); chk("post_resume", ctl(), C_RUN); chk_st("post_resume_st", 2'd0);
    chk_stall("stall_after_halt");
    next_cycle();

    // Reset in the middle of a MUL wait
    id_valid = 1'b1; id_instr = I_NOP; ex_op = 16'h1000;
    next_cycle();
    #1;
    chk_st("pre_rst_st", 2'd1);
    reset_n = 1'b0;
    #1;
    chk_st("rst_mid_st", 2'd0); chk("rst_mid_ctl", ctl(), C_RST);
    stalls = 0; chk_stall("rst_mid_stall");
    next_cycle();
    ex_op = 16'h4000;
    #2 reset_n = 1'b1;
    settle(); chk("rst_release", ctl(), C_RUN); chk_st("rst_release_st", 2'd0);
    next_cycle();

    // Fresh MUL after reset: counter reads exactly its hold cycles
    ex_op = 16'h1000;
    settle(); chk("mul2_a", ctl(), C_MUL); stalls++;
    next_cycle();
    settle(); stalls++;
    next_cycle();
    settle(); stalls++;
    next_cycle();
    settle(); chk("mul2_rel", ctl(), C_RUN);
    next_cycle();
    ex_op = 16'h4000;
    settle(); chk_stall("stall_mul2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
